regfile_wb_arbiter: RTL

- Shares the single write port of the register file (WE/Rw/Din) between N_REQ writeback requesters (e.g. ALU, load unit) using round-robin arbitration with a valid/ready handshake.
- Registers the granted write one cycle before it is presented to the regfile.
- Keeps a busy-register scoreboard: the issue stage marks destinations; writes clear them. It also raises STALL when an operand is still pending.

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared helpers for regfile-side controllers: selector width and the
// round-robin pointer reset value.
package regfile_wb_arbiter_pkg;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer resets to the last index so requester 0 is searched first.
    function automatic int rr_last_reset(input int n_req);
        return n_req - 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past LAST and wraps,
// the first asserted request wins.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW = sel_width(N_REQ)
) (
    input  logic [N_REQ-1:0] REQ,
    input  logic [IW-1:0]    LAST,
    output logic [N_REQ-1:0] GNT,
    output logic [IW-1:0]    GNT_IDX,
    output logic             ANY
);

    int idx;

    always_comb begin
        GNT     = '0;
        GNT_IDX = '0;
        ANY     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(LAST) + k) % N_REQ;
            if (!ANY && REQ[idx]) begin
                ANY      = 1'b1;
                GNT[idx] = 1'b1;
                GNT_IDX  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the regfile write port among N_REQ writeback units,
// with a registered write stage and a busy-register scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int N     = 32,
    parameter int SIZE  = 64,
    localparam int RW   = sel_width(N),
    localparam int IW   = sel_width(N_REQ)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [N_REQ-1:0]      REQ_VALID,
    output logic [N_REQ-1:0]      REQ_READY,
    input  logic [N_REQ*RW-1:0]   REQ_RD,
    input  logic [N_REQ*SIZE-1:0] REQ_DATA,
    output logic                  WE,
    output logic [RW-1:0]         Rw,
    output logic [SIZE-1:0]       Din,
    input  logic                  MARK_EN,
    input  logic [RW-1:0]         MARK_RD,
    input  logic [RW-1:0]         CHK_RA,
    input  logic [RW-1:0]         CHK_RB,
    output logic [N-1:0]          BUSY,
    output logic                  STALL
);

    logic [IW-1:0]    last_reg;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [RW-1:0]    sel_rd;
    logic [SIZE-1:0]  sel_data;
    logic [N-1:0]     busy_next;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .REQ     (REQ_VALID),
        .LAST    (last_reg),
        .GNT     (gnt),
        .GNT_IDX (gnt_idx),
        .ANY     (gnt_any)
    );

    assign REQ_READY = gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = REQ_RD[i*RW +: RW];
                sel_data = REQ_DATA[i*SIZE +: SIZE];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_reg <= IW'(rr_last_reset(N_REQ));
            WE       <= 1'b0;
            Rw       <= '0;
            Din      <= '0;
        end else if (gnt_any) begin
            last_reg <= gnt_idx;
            Rw       <= sel_rd;
            Din      <= sel_data;
            // x0 writes complete the handshake but never reach the regfile.
            WE       <= (sel_rd != '0);
        end else begin
            WE       <= 1'b0;
        end
    end

    // A fresh mark beats a same-edge clear: a newer producer is outstanding.
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < N; gi++) begin : g_busy
        assign busy_next[gi] = (MARK_EN && (MARK_RD == RW'(gi))) ? 1'b1 :
                               (WE && (Rw == RW'(gi)))           ? 1'b0 :
                               BUSY[gi];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BUSY <= '0;
        end else begin
            BUSY <= busy_next;
        end
    end

    assign STALL = BUSY[CHK_RA] | BUSY[CHK_RB];

endmodule
